// File: rtl/cc_speed_tick_gen.sv
// Multi-lane speed tick generator: lane c emits a one-cycle active-low tick every (P >> c) clocks,
// where P is picked by the game level. Optional macro CC_SPEEDTICKGEN_FASTSIM_EN shortens all periods.
module cc_speed_tick_gen #(
   parameter int unsigned DATAWIDTH     = 27,
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned PERIOD_L1     = 32'd16777216,
   parameter int unsigned PERIOD_L2     = 32'd14638608,
   parameter int unsigned PERIOD_L3     = 32'd11000000,
   parameter int unsigned PERIOD_L4     = 32'd8000000,
   parameter int unsigned FASTSIM_SHIFT = 16
) (
   input  logic                CC_SPEEDTICKGEN_CLOCK_50,
   input  logic                CC_SPEEDTICKGEN_RESET_InLow,
   input  logic [2:0]          CC_SPEEDTICKGEN_level_InBUS,
   input  logic                CC_SPEEDTICKGEN_pause_InHigh,
   output logic [CHANNELS-1:0] CC_SPEEDTICKGEN_T0_OutBUS,
   output logic [7:0]          CC_SPEEDTICKGEN_tickcount_OutBUS,
   output logic                CC_SPEEDTICKGEN_active_OutHigh
);

`ifdef CC_SPEEDTICKGEN_FASTSIM_EN
   localparam bit fastsim_on = 1'b1;
`else
   localparam bit fastsim_on = 1'b0;
`endif

   localparam int unsigned eff_shift = fastsim_on ? FASTSIM_SHIFT : 0;
   localparam logic [DATAWIDTH-1:0] min_period = DATAWIDTH'(2);

   // Truncate to the datapath width first, then apply the debug shift and its clamp.
   function automatic logic [DATAWIDTH-1:0] scale_period(input int unsigned period);
      logic [DATAWIDTH-1:0] p;
      p = DATAWIDTH'(period) >> eff_shift;
      if (fastsim_on && (p < min_period)) begin
         p = min_period;
      end
      return p;
   endfunction

   localparam logic [DATAWIDTH-1:0] period_l1 = scale_period(PERIOD_L1);
   localparam logic [DATAWIDTH-1:0] period_l2 = scale_period(PERIOD_L2);
   localparam logic [DATAWIDTH-1:0] period_l3 = scale_period(PERIOD_L3);
   localparam logic [DATAWIDTH-1:0] period_l4 = scale_period(PERIOD_L4);

   logic [2:0]           level_q;
   logic [DATAWIDTH-1:0] cnt_q [CHANNELS];
   logic [DATAWIDTH-1:0] cnt_d [CHANNELS];
   logic [CHANNELS-1:0]  t0_q, t0_d;
   logic [7:0]           tickcount_q, tickcount_d;
   logic                 active_q, active_d;

   logic [DATAWIDTH-1:0] base_period;
   logic [DATAWIDTH-1:0] lane_last [CHANNELS];
   logic                 level_change;
   logic                 level_valid;
   logic                 run;

   always_comb begin
      case (level_q)
         3'd2:    base_period = period_l2;
         3'd3:    base_period = period_l3;
         3'd4:    base_period = period_l4;
         default: base_period = period_l1;
      endcase
   end

   // Terminal count per lane: (P >> c) clamped to 2, minus one.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         logic [DATAWIDTH-1:0] lane_period;
         lane_period = base_period >> c;
         if (lane_period < min_period) begin
            lane_period = min_period;
         end
         lane_last[c] = lane_period - DATAWIDTH'(1);
      end
   end

   assign level_change = (CC_SPEEDTICKGEN_level_InBUS != level_q);
   assign level_valid  = (level_q >= 3'd1) && (level_q <= 3'd4);
   assign run          = level_valid && !CC_SPEEDTICKGEN_pause_InHigh;

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c] = cnt_q[c];
         t0_d[c]  = 1'b1;
         if (level_change) begin
            cnt_d[c] = '0;
         end else if (run) begin
            if (cnt_q[c] == lane_last[c]) begin
               cnt_d[c] = '0;
               t0_d[c]  = 1'b0;
            end else begin
               cnt_d[c] = cnt_q[c] + DATAWIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      tickcount_d = tickcount_q;
      if (level_change) begin
         tickcount_d = 8'd0;
      end else if (!t0_d[0]) begin
         tickcount_d = tickcount_q + 8'd1;
      end
      active_d = run;
   end

   always_ff @(posedge CC_SPEEDTICKGEN_CLOCK_50 or negedge CC_SPEEDTICKGEN_RESET_InLow) begin
      if (!CC_SPEEDTICKGEN_RESET_InLow) begin
         level_q     <= 3'd0;
         t0_q        <= '1;
         tickcount_q <= 8'd0;
         active_q    <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         level_q     <= CC_SPEEDTICKGEN_level_InBUS;
         t0_q        <= t0_d;
         tickcount_q <= tickcount_d;
         active_q    <= active_d;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   assign CC_SPEEDTICKGEN_T0_OutBUS        = t0_q;
   assign CC_SPEEDTICKGEN_tickcount_OutBUS = tickcount_q;
   assign CC_SPEEDTICKGEN_active_OutHigh   = active_q;

`ifndef SYNTHESIS
   // A lane period of at least two clocks means ticks can never be back-to-back.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_no_b2b
      assert property (@(posedge CC_SPEEDTICKGEN_CLOCK_50)
                       disable iff (!CC_SPEEDTICKGEN_RESET_InLow)
                       !t0_q[c] |=> t0_q[c]);
   end
`endif

endmodule
